// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg : shared state encoding and default timing for btn_debounce
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package debounce_pkg;

  localparam logic [1:0] ST_LO      = 2'b00;
  localparam logic [1:0] ST_WAIT_HI = 2'b01;
  localparam logic [1:0] ST_HI      = 2'b10;
  localparam logic [1:0] ST_WAIT_LO = 2'b11;

  // 10 ms at 100 MHz
  localparam int DEFAULT_STABLE_CNT = 1_000_000;
  localparam int DEFAULT_CNT_W      = 20;

  typedef enum logic [1:0] {
    S_LO      = ST_LO,
    S_WAIT_HI = ST_WAIT_HI,
    S_HI      = ST_HI,
    S_WAIT_LO = ST_WAIT_LO
  } state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_sync2.sv
// ---------------------------------------------------------------------------
// sync2 : two-flop synchronizer for a single asynchronous level
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : synchronizes a bouncing button and qualifies each level
//                change over STABLE_CNT consecutive stable clocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic db,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             busy_q, busy_d;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (s)
  );

  // Counter defaults to zero so it is held clear everywhere except while counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_LO: begin
        if (s) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (!s)                     state_d = S_LO;
        else if (cnt_q == CNT_LAST) state_d = S_HI;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      S_HI: begin
        if (!s) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (s)                      state_d = S_HI;
        else if (cnt_q == CNT_LAST) state_d = S_LO;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_LO;
    endcase
    db_d   = (state_d == S_HI)      || (state_d == S_WAIT_LO);
    busy_d = (state_d == S_WAIT_HI) || (state_d == S_WAIT_LO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      busy_q  <= busy_d;
    end
  end

  assign db   = db_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Conditions a raw, bouncing push-button or switch input into a clean, glitch-free level. It sits directly upstream of the positive-edge detector, whose one-clock pulse generator consumes the debounced level `db`. The block contains a 2-flop synchronizer, a stability counter and a 4-state FSM. `db` changes only after the synchronized input has held a new value for STABLE_CNT consecutive clocks.

Parameters:
- STABLE_CNT, 1_000_000: clocks the synchronized input must stay constant before `db` follows it. 10 ms at 100 MHz. Legal range ≥ 1. Benches override it small.
- CNT_W, 20: counter width. Must satisfy 2^CNT_W > STABLE_CNT.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
- d  input  1  raw asynchronous button/switch level
- db  output  1  debounced level, registered
- busy  output  1  1 while a candidate transition is being qualified (WAIT_HI or WAIT_LO), registered

Behaviour:
- Reset (rst=0, asynchronous): sync flops=0, state=LO, cnt=0, db=0, busy=0. Release is synchronous to clk. A reset mid-qualification abandons it; `db` returns to 0 immediately.
- Synchronizer:
  - s1<=d, s<=s1 every clock.
  - `s` is the only input to the FSM; `d` is never used combinationally.
- FSM states: LO, WAIT_HI, HI, WAIT_LO. Encoding is in the package.
  - LO: if s=1, go to WAIT_HI and set cnt<=0; else stay.
  - WAIT_HI:
    - if s=0, go to LO and set cnt<=0 (bounce rejected);
    - else if cnt==STABLE_CNT-1, go to HI;
    - else cnt<=cnt+1.
  - HI: if s=0, go to WAIT_LO and set cnt<=0; else stay.
  - WAIT_LO: mirror of WAIT_HI. s=1 returns to HI; the count reaching STABLE_CNT-1 goes to LO.
- Outputs (registered, updated on the same edge as the state transition):
  - db=1 in HI and WAIT_LO, 0 in LO and WAIT_HI.
  - busy=1 in WAIT_HI and WAIT_LO.
- Latency:
  - Let edge 0 be the first rising edge at which d=1 is captured into s1.
  - With d held, db=1 is visible after edge STABLE_CNT+2.
  - The falling direction is symmetric.
- Bounce rejection:
  - Any reversal of s before the count completes returns to the prior stable state with cnt cleared. db never toggles.
  - A glitch of fewer than STABLE_CNT clocks (as seen at s) never reaches db.
- Counter:
  - Unsigned, CNT_W bits.
  - Never exceeds STABLE_CNT-1, so there is no wrap-around.
  - Held at 0 in LO and HI.
- STABLE_CNT=1: WAIT states last exactly one clock.
- db is glitch-free and changes at most once per STABLE_CNT+1 clocks.

Decomposition:
- Package debounce_pkg:
  - state encoding localparams ST_LO=2'b00, ST_WAIT_HI=2'b01, ST_HI=2'b10, ST_WAIT_LO=2'b11;
  - default STABLE_CNT constant.
- One natural sub-module, sync2: a 2-flop synchronizer with clk and rst (async active-low, resets to 0), d in, q out. It is reusable for other asynchronous inputs.
- The FSM and counter stay in btn_debounce.

Test Plan (STABLE_CNT=4, CNT_W=3):
- Reset: hold rst=0 with d=1 for 5 clocks, then release. Required: db=0 and busy=0 during reset; db rises 6 edges after the first edge sampling d=1 after release.
- Clean press: d 0→1 captured at edge 0 and held. Required: busy=1 after edges 2–5, db=1 after edge 6, busy=0 after edge 6.
- Bounce on press: d=1 for 2 clocks, 0 for 1 clock, then 1 held. Required: db stays 0 through the glitch; cnt clears; db rises 6 edges after the final 0→1 capture.
- Release with bounce: from db=1, d=0 for 3 clocks, 1 for 1 clock, 0 held. Required: db stays 1 during the glitch, then falls 6 edges after the final 1→0 capture.
- Short glitch: from LO, a one-clock d=1 pulse. Required: busy pulses for 1 clock, db never asserts.
- Reset mid-qualification: assert rst=0 when cnt=2 in WAIT_HI. Required: db=0, busy=0 and state LO immediately; after release the full 6-edge qualification repeats.
